// File: rtl/fx_reg_file.sv
// fx_reg_file: multi-port register file with two write ports, same-cycle
// write forwarding, an optional hardwired zero register and a pending-write
// scoreboard for long-latency writebacks. Port B wins a same-address
// collision with port A. err_collide and err_stray are registered pulses.
module fx_reg_file #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [DATA_W-1:0]        wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [DEPTH-1:0]         pending,
  output logic                     err_collide,
  output logic                     err_stray
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              collide_q, collide_d;
  logic              stray_q, stray_d;
  logic              wa_live, wb_live, same_addr;

  // Qualify write ports: writes to the hardwired zero register are dropped
  always_comb begin
    wa_live   = wa_en & !((ZERO_REG != 0) && (wa_addr == '0));
    wb_live   = wb_en & !((ZERO_REG != 0) && (wb_addr == '0));
    same_addr = (wa_addr == wb_addr);
  end

  // Reservation acceptance: free register, or one being released this cycle
  always_comb begin
    rsv_ok = rsv_en & !reset
           & !((ZERO_REG != 0) && (rsv_addr == '0))
           & (!pend_q[rsv_addr] | (wb_en & (wb_addr == rsv_addr)));
  end

  // Scoreboard next state: wb clears, a same-cycle reservation re-sets
  always_comb begin
    pend_d = pend_q;
    if (wb_live) pend_d[wb_addr] = 1'b0;
    if (rsv_ok)  pend_d[rsv_addr] = 1'b1;
    collide_d = wa_live & wb_live & same_addr;
    stray_d   = wb_live & !pend_q[wb_addr];
  end

  // Register storage; port B takes priority on a shared address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wa_live && !(wb_live && same_addr)) mem_q[wa_addr] <= wa_data;
      if (wb_live) mem_q[wb_addr] <= wb_data;
    end
  end

  // Scoreboard and error pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q    <= '0;
      collide_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      collide_q <= collide_d;
      stray_q   <= stray_d;
    end
  end

  // Combinational read ports with zero register, forwarding and busy flags
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              zr;
      a  = rd_addr[k*ADDR_W +: ADDR_W];
      zr = (ZERO_REG != 0) && (a == '0);
      if (zr)
        d = '0;
      else if ((BYPASS != 0) && !reset && wb_en && (wb_addr == a))
        d = wb_data;
      else if ((BYPASS != 0) && !reset && wa_en && (wa_addr == a))
        d = wa_data;
      else
        d = mem_q[a];
      rd_data[k*DATA_W +: DATA_W] = d;
      rd_busy[k] = !zr & pend_q[a] & !(wb_en & (wb_addr == a));
    end
  end

  assign pending     = pend_q;
  assign err_collide = collide_q;
  assign err_stray   = stray_q;

endmodule

// File: tb/tb_fx_reg_file.sv
// Scoreboard bench for fx_reg_file: the stimulus process drives inputs on the
// falling edge, derives expected outputs from an array-based model and queues
// them; the monitor pops and compares shortly after, before the rising edge.
module tb_fx_reg_file;
  localparam int DW = 64;
  localparam int DP = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_busy;
  logic           wa_en, wb_en, rsv_en;
  logic [AW-1:0]  wa_addr, wb_addr, rsv_addr;
  logic [DW-1:0]  wa_data, wb_data;
  logic           rsv_ok;
  logic [DP-1:0]  pending;
  logic           err_collide, err_stray;

  fx_reg_file #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .NUM_RD(NR),
                .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(rsv_ok), .pending(pending),
    .err_collide(err_collide), .err_stray(err_stray));

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [DW-1:0] rd [NR];
    logic [NR-1:0] busy;
    logic          ok;
    logic [DP-1:0] pend;
    logic          ec;
    logic          es;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Reference model state
  logic [DW-1:0] m_mem [DP];
  bit            m_pend [DP];
  bit            m_ec, m_es;

  function automatic logic [DP-1:0] pend_vec();
    logic [DP-1:0] v;
    for (int i = 0; i < DP; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DP; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 0;
    end
    m_ec = 0;
    m_es = 0;
  endtask

  // Compute expected outputs for the inputs now driven, then advance model.
  task automatic predict();
    exp_t e;
    e.id = step_id;
    if (reset) begin
      for (int k = 0; k < NR; k++) e.rd[k] = '0;
      e.busy = '0;
      e.ok   = 0;
      e.pend = '0;
      e.ec   = 0;
      e.es   = 0;
      model_clear();
    end else begin
      bit ok, wa_w, wb_w;
      e.pend = pend_vec();
      e.ec   = m_ec;
      e.es   = m_es;
      for (int k = 0; k < NR; k++) begin
        int a;
        a = int'(rd_addr[k*AW +: AW]);
        if (a == 0)                             e.rd[k] = '0;
        else if (wb_en && int'(wb_addr) == a)   e.rd[k] = wb_data;
        else if (wa_en && int'(wa_addr) == a)   e.rd[k] = wa_data;
        else                                    e.rd[k] = m_mem[a];
        e.busy[k] = (a != 0) && m_pend[a] && !(wb_en && int'(wb_addr) == a);
      end
      ok = rsv_en && rsv_addr != 0 &&
           (!m_pend[rsv_addr] || (wb_en && wb_addr == rsv_addr));
      e.ok = ok;
      wa_w = wa_en && wa_addr != 0;
      wb_w = wb_en && wb_addr != 0;
      m_ec = wa_w && wb_w && wa_addr == wb_addr;
      m_es = wb_w && !m_pend[wb_addr];
      if (wa_w) m_mem[wa_addr] = wa_data;
      if (wb_w) begin
        m_mem[wb_addr]  = wb_data;
        m_pend[wb_addr] = 0;
      end
      if (ok) m_pend[rsv_addr] = 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst,
                       input logic a_en, input int a_ad, input logic [DW-1:0] a_d,
                       input logic b_en, input int b_ad, input logic [DW-1:0] b_d,
                       input logic r_en, input int r_ad,
                       input int r0, input int r1, input int r2);
    reset    = rst;
    wa_en    = a_en; wa_addr = AW'(a_ad); wa_data = a_d;
    wb_en    = b_en; wb_addr = AW'(b_ad); wb_data = b_d;
    rsv_en   = r_en; rsv_addr = AW'(r_ad);
    rd_addr  = {AW'(r2), AW'(r1), AW'(r0)};
    step_id++;
    predict();
    @(negedge clk);
  endtask

  task automatic idle(input int r0, input int r1, input int r2);
    drive(0, 0, 0, '0, 0, 0, '0, 0, 0, r0, r1, r2);
  endtask

  task automatic cmp(input string name, input int id,
                     input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        for (int k = 0; k < NR; k++)
          cmp($sformatf("rd_data%0d", k), e.id, rd_data[k*DW +: DW], e.rd[k]);
        cmp("rd_busy", e.id, DW'(rd_busy), DW'(e.busy));
        cmp("rsv_ok", e.id, DW'(rsv_ok), DW'(e.ok));
        cmp("pending", e.id, DW'(pending), DW'(e.pend));
        cmp("err_collide", e.id, DW'(err_collide), DW'(e.ec));
        cmp("err_stray", e.id, DW'(err_stray), DW'(e.es));
      end
    end
  end

  initial begin
    reset = 1'b1;
    wa_en = 0; wb_en = 0; rsv_en = 0;
    wa_addr = '0; wb_addr = '0; rsv_addr = '0;
    wa_data = '0; wb_data = '0; rd_addr = '0;
    model_clear();
    @(negedge clk);

    // Reset state while writes are attempted
    drive(1, 1, 5, 64'h1234, 1, 6, 64'h5678, 1, 7, 5, 6, 7);
    drive(1, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0, 0);

    // Write/read with forwarding, then the stored value
    drive(0, 1, 5, 64'h0001_0000_0000_0000, 0, 0, '0, 0, 0, 5, 0, 5);
    idle(5, 5, 0);

    // Zero register ignores writes, no error pulses
    drive(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, '0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);

    // Reservation, duplicate refusal, release by wb with forwarding
    drive(0, 0, 0, '0, 0, 0, '0, 1, 7, 7, 0, 0);
    drive(0, 0, 0, '0, 0, 0, '0, 1, 7, 7, 7, 0);
    drive(0, 0, 0, '0, 1, 7, 64'h2A, 0, 0, 7, 0, 0);
    idle(7, 0, 0);

    // Re-reservation in the same cycle as the releasing wb
    drive(0, 0, 0, '0, 0, 0, '0, 1, 8, 0, 0, 0);
    drive(0, 0, 0, '0, 1, 8, 64'h88, 1, 8, 8, 0, 0);
    idle(8, 0, 0);

    // Collision on a pending register
    drive(0, 0, 0, '0, 0, 0, '0, 1, 3, 0, 0, 0);
    drive(0, 1, 3, 64'h11, 1, 3, 64'h22, 0, 0, 3, 0, 0);
    idle(3, 0, 0);
    idle(3, 0, 0);

    // Stray writeback
    drive(0, 0, 0, '0, 1, 9, 64'h99, 0, 0, 9, 0, 0);
    idle(9, 0, 0);
    idle(9, 0, 0);

    // Reset discards an outstanding reservation; later wb is stray
    drive(0, 0, 0, '0, 0, 0, '0, 1, 12, 12, 0, 0);
    idle(12, 5, 3);
    drive(1, 1, 4, 64'h44, 1, 12, 64'hC, 1, 13, 12, 5, 4);
    drive(0, 0, 0, '0, 1, 12, 64'hCC, 0, 0, 12, 5, 0);
    idle(12, 0, 0);

    // Randomized traffic on a narrow address range to force hits
    for (int n = 0; n < 2000; n++) begin
      logic [DW-1:0] da, db;
      da = {$urandom(), $urandom()};
      db = {$urandom(), $urandom()};
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 7), da,
            ($urandom_range(0, 2) == 0), $urandom_range(0, 7), db,
            ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    end

    idle(0, 0, 0);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fx_reg_file.md
FX_REG_FILE -- requirements
Module: fx_reg_file

Interface
REQ-001 Parameter DATA_W, default 64, register width in bits (signed q15.48 at default).
REQ-002 Parameter DEPTH, default 32, number of registers; power of two, >=2.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 Parameter NUM_RD, default 3, number of read ports, 1..4.
REQ-005 Parameter ZERO_REG, default 1, when 1 register 0 reads 0 and ignores writes/reservations.
REQ-006 Parameter BYPASS, default 1, when 1 same-cycle write data is forwarded to read ports.
REQ-007 clk  input  1  clock, all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 rd_addr  input  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-010 rd_data  output  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-011 rd_busy  output  NUM_RD  port k register has an outstanding reservation.
REQ-012 wa_en / wa_addr / wa_data  input  1 / ADDR_W / DATA_W  write port A (single-cycle pipeline writeback).
REQ-013 wb_en / wb_addr / wb_data  input  1 / ADDR_W / DATA_W  write port B (long-latency unit writeback; clears reservation).
REQ-014 rsv_en / rsv_addr  input  1 / ADDR_W  request to mark a register pending.
REQ-015 rsv_ok  output  1  reservation accepted this cycle.
REQ-016 pending  output  DEPTH  registered scoreboard, bit i = register i pending.
REQ-017 err_collide  output  1  registered pulse: wa and wb wrote same address previous cycle.
REQ-018 err_stray  output  1  registered pulse: wb wrote non-pending register previous cycle.

Function
REQ-019 Storage SHALL be DEPTH x DATA_W registers; writes take effect on the rising clk edge.
REQ-020 Read ports SHALL be combinational; rd_data[k] = 0 if ZERO_REG and address 0; else wb_data if BYPASS, wb_en, wb_addr match; else wa_data if BYPASS, wa_en, wa_addr match; else stored value.
REQ-021 With BYPASS=0, reads SHALL return stored value only (write visible the cycle after the edge).
REQ-022 wa_en and wb_en to the same address in one cycle: port B data SHALL be stored, port A dropped, err_collide=1 next cycle for one cycle.
REQ-023 Writes to address 0 with ZERO_REG=1 SHALL be discarded and SHALL NOT raise err_collide/err_stray.
REQ-024 rsv_ok SHALL be combinational: rsv_en & (ZERO_REG=0 or rsv_addr!=0) & (pending[rsv_addr]=0 or (wb_en & wb_addr==rsv_addr)).
REQ-025 On rsv_ok, pending[rsv_addr] SHALL be 1 after the edge; a same-address wb clear in that cycle SHALL be overridden by the set.
REQ-026 wb_en to pending register SHALL clear its pending bit at the edge (unless REQ-025 applies).
REQ-027 wb_en to non-pending register SHALL still write data and SHALL pulse err_stray next cycle.
REQ-028 wa_en to a pending register SHALL write data and SHALL leave pending unchanged.
REQ-029 rd_busy[k] SHALL equal pending[rd_addr[k]] & !(wb_en & wb_addr==rd_addr[k]); 0 for address 0 with ZERO_REG=1.
REQ-030 Latency: write-to-read 0 cycles with BYPASS=1, 1 cycle with BYPASS=0; reservation-to-busy 1 cycle.

Reset
REQ-031 reset high SHALL immediately clear all registers, pending, err_collide, err_stray to 0, independent of clk.
REQ-032 While reset is high, writes and reservations SHALL be ignored; rd_data SHALL read 0 (bypass suppressed), rsv_ok=0.
REQ-033 Reset asserted mid-reservation SHALL discard it; a later wb to that register SHALL raise err_stray.

Verification
REQ-034 Write/read: wa writes 0x0001_0000_0000_0000 to r5; same cycle rd_addr0=5 -> rd_data0 equals it (BYPASS=1); next cycle stored value identical.
REQ-035 Zero reg: wa writes 0xFFFF_FFFF_FFFF_FFFF to r0 -> all ports reading r0 return 0, no error pulses.
REQ-036 Scoreboard: rsv r7 -> rsv_ok=1, pending[7]=1, rd_busy=1 next cycle; second rsv r7 -> rsv_ok=0; wb r7 data 0x2A -> busy 0 same cycle, pending[7]=0 after edge, read 0x2A.
REQ-037 Collision: wa r3=0x11, wb r3=0x22 same cycle (r3 pending) -> r3=0x22, err_collide=1 for one cycle, pending[3]=0.
REQ-038 Stray/reset: wb r9 with pending[9]=0 -> err_stray=1 one cycle; reset mid-test -> all regs, pending, flags 0 before next clk edge.
